// File: rtl/afe_emu_pkg.sv
// Shared types and constants for the AFE/DVP emulator: pattern modes,
// line FSM states and the noise LFSR definition.
package afe_emu_pkg;

  localparam int unsigned LFSR_W = 16;

  localparam logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1;
  // Fibonacci taps 16,14,13,11 expressed as right-shift feedback bits 0,2,3,5
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'h002D;

  typedef enum logic [1:0] {
    MODE_FIXED = 2'd0,
    MODE_HRAMP = 2'd1,
    MODE_VRAMP = 2'd2,
    MODE_LFSR  = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_OB     = 2'd1,
    ST_ACTIVE = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    return {^(s & LFSR_TAPS), s[LFSR_W-1:1]};
  endfunction

endpackage

// File: rtl/afe_emu_delay.sv
// Fixed-depth register pipeline with synchronous clear; models the AFE
// output latency between the sample generator and the DVP data pins.
module afe_emu_delay #(
  parameter int unsigned W     = 14,
  parameter int unsigned DEPTH = 3
) (
  input  logic         clk,
  input  logic         clr_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] pipe_q [DEPTH];

  always_ff @(posedge clk) begin
    if (clr_i) begin
      for (int i = 0; i < int'(DEPTH); i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= d_i;
      for (int i = 1; i < int'(DEPTH); i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign q_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/afe_dvp_emulator.sv
// CCD analog front-end stand-in: follows system HSYNC/VSYNC and returns an
// optical-black lead-in plus a selectable test pattern on the DVP data bus.
module afe_dvp_emulator
  import afe_emu_pkg::*;
#(
  parameter int unsigned     DW       = 14,
  parameter int unsigned     H_ACT    = 1600,
  parameter int unsigned     OB_PIX   = 24,
  parameter logic [DW-1:0]   OB_LEVEL = DW'(64),
  parameter int unsigned     DATA_LAT = 3,
  parameter int unsigned     CW       = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          dvp_hsync,
  input  logic          dvp_vsync,
  input  logic [1:0]    mode,
  input  logic          clr,
  output logic [DW-1:0] dvp_d,
  output logic [CW-1:0] line_cnt,
  output logic [15:0]   frame_cnt,
  output logic          line_abort
);

  localparam logic [CW-1:0] OB_LAST  = CW'(OB_PIX - 1);
  localparam logic [CW-1:0] ACT_LAST = CW'(H_ACT - 1);
  localparam logic [CW-1:0] CNT_MAX  = '1;

  logic                hs_q, hs_prev_q, vs_q, vs_prev_q;
  logic                hs_edge_c, vs_edge_c, abort_set_c;
  state_e              state_q;
  mode_e               mode_q;
  logic [CW-1:0]       x_q, y_q, line_cnt_q;
  logic [15:0]         frame_cnt_q;
  logic                abort_q;
  logic [LFSR_W-1:0]   lfsr_q;
  logic [DW-1:0]       pix0_c;

  // Sync sampling; edges are seen one cycle after the pins go high
  always_ff @(posedge clk) begin
    if (rst) begin
      hs_q      <= 1'b0;
      hs_prev_q <= 1'b0;
      vs_q      <= 1'b0;
      vs_prev_q <= 1'b0;
    end else begin
      hs_q      <= dvp_hsync;
      hs_prev_q <= hs_q;
      vs_q      <= dvp_vsync;
      vs_prev_q <= vs_q;
    end
  end

  assign hs_edge_c   = hs_q & ~hs_prev_q;
  assign vs_edge_c   = vs_q & ~vs_prev_q;
  assign abort_set_c = hs_edge_c && (state_q == ST_OB || state_q == ST_ACTIVE);

  // Line FSM, x/y and frame counters, LFSR
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      mode_q      <= MODE_FIXED;
      x_q         <= '0;
      y_q         <= '0;
      line_cnt_q  <= '0;
      frame_cnt_q <= '0;
      abort_q     <= 1'b0;
      lfsr_q      <= LFSR_SEED;
    end else begin
      abort_q <= abort_set_c | (abort_q & ~clr);

      if (hs_edge_c) begin
        state_q <= ST_OB;
        x_q     <= '0;
        mode_q  <= mode_e'(mode);
        // vsync in the same cycle takes effect first: this line is y=0
        if (vs_edge_c) begin
          y_q        <= '0;
          line_cnt_q <= CW'(1);
        end else begin
          y_q <= line_cnt_q;
          if (line_cnt_q != CNT_MAX) line_cnt_q <= line_cnt_q + CW'(1);
        end
      end else begin
        if (vs_edge_c) begin
          y_q        <= '0;
          line_cnt_q <= '0;
        end
        case (state_q)
          ST_OB: begin
            if (x_q == OB_LAST) begin
              state_q <= ST_ACTIVE;
              x_q     <= '0;
            end else begin
              x_q <= x_q + CW'(1);
            end
          end
          ST_ACTIVE: begin
            if (x_q == ACT_LAST) begin
              state_q <= ST_DONE;
              x_q     <= '0;
            end else begin
              x_q <= x_q + CW'(1);
            end
          end
          default: ;
        endcase
      end

      if (vs_edge_c) frame_cnt_q <= frame_cnt_q + 16'd1;

      if (vs_edge_c) begin
        lfsr_q <= LFSR_SEED;
      end else if (state_q == ST_ACTIVE) begin
        lfsr_q <= lfsr_next(lfsr_q);
      end
    end
  end

  // Stage-0 sample selection
  always_comb begin
    pix0_c = '0;
    case (state_q)
      ST_OB: pix0_c = OB_LEVEL;
      ST_ACTIVE: begin
        case (mode_q)
          MODE_FIXED: pix0_c = OB_LEVEL;
          MODE_HRAMP: pix0_c = DW'(x_q);
          MODE_VRAMP: pix0_c = DW'(y_q);
          MODE_LFSR:  pix0_c = DW'(lfsr_q);
          default:    pix0_c = '0;
        endcase
      end
      default: pix0_c = '0;
    endcase
  end

  afe_emu_delay #(
    .W     (DW),
    .DEPTH (DATA_LAT)
  ) u_delay (
    .clk   (clk),
    .clr_i (rst),
    .d_i   (pix0_c),
    .q_o   (dvp_d)
  );

  assign line_cnt   = line_cnt_q;
  assign frame_cnt  = frame_cnt_q;
  assign line_abort = abort_q;

endmodule

// File: tb/tb_afe_dvp_emulator.sv
// Self-checking bench for afe_dvp_emulator: a scoreboard queue of expected
// per-cycle dvp_d samples plus direct checks of the counters and abort flag.
module tb_afe_dvp_emulator;

  localparam int unsigned DW       = 14;
  localparam int unsigned H_ACT    = 16;
  localparam int unsigned OB_PIX   = 4;
  localparam int unsigned DATA_LAT = 3;
  localparam int unsigned CW       = 12;
  localparam logic [DW-1:0] OB_LVL  = 14'd64;
  localparam logic [CW-1:0] CNT_MAX = 12'hFFF;
  localparam int unsigned NO_CUT   = 32'hFFFF_FFFF;

  typedef struct {
    int unsigned   cyc;
    logic [DW-1:0] val;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          dvp_hsync = 1'b0;
  logic          dvp_vsync = 1'b0;
  logic [1:0]    mode = 2'd0;
  logic          clr = 1'b0;
  logic [DW-1:0] dvp_d;
  logic [CW-1:0] line_cnt;
  logic [15:0]   frame_cnt;
  logic          line_abort;

  int unsigned cyc    = 0;
  int unsigned checks = 0;
  int unsigned errors = 0;
  exp_t        exp_q[$];

  logic [CW-1:0] m_line_cnt  = '0;
  logic [15:0]   m_frame_cnt = '0;
  logic [15:0]   m_lfsr      = 16'hACE1;

  afe_dvp_emulator #(
    .DW       (DW),
    .H_ACT    (H_ACT),
    .OB_PIX   (OB_PIX),
    .OB_LEVEL (OB_LVL),
    .DATA_LAT (DATA_LAT),
    .CW       (CW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .dvp_hsync  (dvp_hsync),
    .dvp_vsync  (dvp_vsync),
    .mode       (mode),
    .clr        (clr),
    .dvp_d      (dvp_d),
    .line_cnt   (line_cnt),
    .frame_cnt  (frame_cnt),
    .line_abort (line_abort)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // x^16+x^14+x^13+x^11+1, shifting right, feedback into bit 15
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    logic fb;
    fb = s[0] ^ s[2] ^ s[3] ^ s[5];
    return {fb, s[15:1]};
  endfunction

  function automatic exp_t mk(input int unsigned c, input logic [DW-1:0] v);
    exp_t e;
    e.cyc = c;
    e.val = v;
    return e;
  endfunction

  // One-cycle sync pulse; n is the cycle it is sampled, y the line's row
  task automatic pulse(input logic hs, input logic vs,
                       output int unsigned n, output logic [CW-1:0] y);
    n = cyc + 1;
    dvp_hsync = hs;
    dvp_vsync = vs;
    tick();
    dvp_hsync = 1'b0;
    dvp_vsync = 1'b0;
    y = '0;
    if (vs) begin
      m_frame_cnt = m_frame_cnt + 16'd1;
      m_lfsr      = 16'hACE1;
      m_line_cnt  = '0;
    end
    if (hs) begin
      y = m_line_cnt;
      if (m_line_cnt != CNT_MAX) m_line_cnt = m_line_cnt + 12'd1;
    end
  endtask

  // Expected dvp_d samples of a line whose hsync is sampled in cycle n
  task automatic push_line(input int unsigned n, input int unsigned cutoff, input bit lead,
                           input logic [1:0] md, input logic [CW-1:0] y);
    int unsigned   base;
    logic [DW-1:0] v;
    if (lead)
      for (int unsigned k = 1; k <= DATA_LAT; k++) exp_q.push_back(mk(n + k, '0));
    base = n + 1 + DATA_LAT;
    for (int unsigned k = 0; k < OB_PIX; k++)
      if (base + k <= cutoff) exp_q.push_back(mk(base + k, OB_LVL));
    base = base + OB_PIX;
    for (int unsigned i = 0; i < H_ACT; i++) begin
      case (md)
        2'd0:    v = OB_LVL;
        2'd1:    v = DW'(i);
        2'd2:    v = DW'(y);
        default: begin
          v      = m_lfsr[DW-1:0];
          m_lfsr = lfsr_step(m_lfsr);
        end
      endcase
      if (base + i <= cutoff) exp_q.push_back(mk(base + i, v));
    end
    base = base + H_ACT;
    for (int unsigned k = 0; k < 3; k++)
      if (base + k <= cutoff) exp_q.push_back(mk(base + k, '0));
  endtask

  task automatic test_reset();
    int unsigned   n;
    logic [CW-1:0] y;
    rst = 1'b1;
    repeat (4) tick();
    rst = 1'b0;
    tick();
    checks++; if (dvp_d !== '0) begin errors++; $display("FAIL reset0_dvp_d got %0h exp 0", dvp_d); end
    checks++; if (line_cnt !== '0) begin errors++; $display("FAIL reset0_line_cnt got %0d exp 0", line_cnt); end
    checks++; if (frame_cnt !== '0) begin errors++; $display("FAIL reset0_frame_cnt got %0d exp 0", frame_cnt); end
    checks++; if (line_abort !== 1'b0) begin errors++; $display("FAIL reset0_abort got %0b exp 0", line_abort); end

    // Build up state mid-line, then reset on top of it
    mode = 2'd0;
    pulse(1'b0, 1'b1, n, y);
    tick();
    pulse(1'b1, 1'b0, n, y);
    tick();
    pulse(1'b1, 1'b0, n, y);
    repeat (6) tick();
    checks++; if (dvp_d !== OB_LVL) begin errors++; $display("FAIL pre_reset_dvp_d got %0h exp %0h", dvp_d, OB_LVL); end
    checks++; if (line_abort !== 1'b1) begin errors++; $display("FAIL pre_reset_abort got %0b exp 1", line_abort); end
    checks++; if (frame_cnt !== m_frame_cnt) begin errors++; $display("FAIL pre_reset_frame_cnt got %0d exp %0d", frame_cnt, m_frame_cnt); end
    checks++; if (line_cnt !== m_line_cnt) begin errors++; $display("FAIL pre_reset_line_cnt got %0d exp %0d", line_cnt, m_line_cnt); end

    rst = 1'b1;
    repeat (4) tick();
    rst = 1'b0;
    tick();
    checks++; if (dvp_d !== '0) begin errors++; $display("FAIL reset_mid_dvp_d got %0h exp 0", dvp_d); end
    checks++; if (line_cnt !== '0) begin errors++; $display("FAIL reset_mid_line_cnt got %0d exp 0", line_cnt); end
    checks++; if (frame_cnt !== '0) begin errors++; $display("FAIL reset_mid_frame_cnt got %0d exp 0", frame_cnt); end
    checks++; if (line_abort !== 1'b0) begin errors++; $display("FAIL reset_mid_abort got %0b exp 0", line_abort); end
    m_line_cnt  = '0;
    m_frame_cnt = '0;
    m_lfsr      = 16'hACE1;
  endtask

  task automatic test_hramp();
    int unsigned   n, guard;
    logic [CW-1:0] y, old_lc;
    exp_t          e;
    mode = 2'd1;
    tick();
    old_lc = m_line_cnt;
    pulse(1'b1, 1'b0, n, y);
    push_line(n, NO_CUT, 1'b1, 2'd1, y);
    checks++; if (line_cnt !== old_lc) begin errors++; $display("FAIL hramp_lc_early got %0d exp %0d", line_cnt, old_lc); end
    guard = 0;
    while (exp_q.size() != 0 && guard < 200) begin
      tick();
      guard++;
      if (cyc == n + 1) begin
        checks++; if (line_cnt !== m_line_cnt) begin errors++; $display("FAIL hramp_lc_update got %0d exp %0d", line_cnt, m_line_cnt); end
      end
      if (cyc == n + 6) mode = 2'd2;
      if (exp_q[0].cyc == cyc) begin
        e = exp_q.pop_front();
        checks++; if (dvp_d !== e.val) begin errors++; $display("FAIL hramp_pix cyc %0d got %0h exp %0h", cyc - n, dvp_d, e.val); end
      end
    end
    if (exp_q.size() != 0) begin checks++; errors++; $display("FAIL hramp_timeout left %0d exp 0", exp_q.size()); exp_q.delete(); end
    mode = 2'd1;
  endtask

  task automatic test_vramp();
    int unsigned   n, guard;
    logic [CW-1:0] y;
    exp_t          e;
    mode = 2'd2;
    pulse(1'b0, 1'b1, n, y);
    repeat (2) tick();
    for (int l = 0; l < 3; l++) begin
      pulse(1'b1, 1'b0, n, y);
      push_line(n, NO_CUT, 1'b1, 2'd2, y);
      guard = 0;
      while (exp_q.size() != 0 && guard < 200) begin
        tick();
        guard++;
        if (exp_q[0].cyc == cyc) begin
          e = exp_q.pop_front();
          checks++; if (dvp_d !== e.val) begin errors++; $display("FAIL vramp_pix line %0d got %0h exp %0h", l, dvp_d, e.val); end
        end
      end
      if (exp_q.size() != 0) begin checks++; errors++; $display("FAIL vramp_timeout left %0d exp 0", exp_q.size()); exp_q.delete(); end
    end
    checks++; if (frame_cnt !== m_frame_cnt) begin errors++; $display("FAIL vramp_frame_cnt got %0d exp %0d", frame_cnt, m_frame_cnt); end
    checks++; if (line_cnt !== 12'd3) begin errors++; $display("FAIL vramp_line_cnt got %0d exp 3", line_cnt); end
  endtask

  task automatic test_abort();
    int unsigned   n, n2, guard;
    logic [CW-1:0] y, y2;
    exp_t          e;
    mode = 2'd1;
    tick();
    pulse(1'b1, 1'b0, n, y);
    n2 = n + 8;
    push_line(n, n2 + DATA_LAT, 1'b1, 2'd1, y);
    y2 = m_line_cnt;
    if (m_line_cnt != CNT_MAX) m_line_cnt = m_line_cnt + 12'd1;
    push_line(n2, NO_CUT, 1'b0, 2'd1, y2);
    guard = 0;
    while (exp_q.size() != 0 && guard < 200) begin
      tick();
      guard++;
      if (cyc == n2 - 1) dvp_hsync = 1'b1;
      if (cyc == n2) begin
        dvp_hsync = 1'b0;
        clr = 1'b1;
        checks++; if (line_abort !== 1'b0) begin errors++; $display("FAIL abort_before got %0b exp 0", line_abort); end
      end
      if (cyc == n2 + 1) begin
        clr = 1'b0;
        checks++; if (line_abort !== 1'b1) begin errors++; $display("FAIL abort_set_vs_clr got %0b exp 1", line_abort); end
      end
      if (exp_q[0].cyc == cyc) begin
        e = exp_q.pop_front();
        checks++; if (dvp_d !== e.val) begin errors++; $display("FAIL abort_pix cyc %0d got %0h exp %0h", cyc - n, dvp_d, e.val); end
      end
    end
    if (exp_q.size() != 0) begin checks++; errors++; $display("FAIL abort_timeout left %0d exp 0", exp_q.size()); exp_q.delete(); end
    checks++; if (line_abort !== 1'b1) begin errors++; $display("FAIL abort_sticky got %0b exp 1", line_abort); end
    checks++; if (line_cnt !== m_line_cnt) begin errors++; $display("FAIL abort_line_cnt got %0d exp %0d", line_cnt, m_line_cnt); end
    clr = 1'b1;
    tick();
    clr = 1'b0;
    checks++; if (line_abort !== 1'b0) begin errors++; $display("FAIL abort_clr got %0b exp 0", line_abort); end
  endtask

  task automatic test_simultaneous();
    int unsigned   n, guard;
    logic [CW-1:0] y;
    logic [15:0]   old_f;
    exp_t          e;
    mode = 2'd2;
    tick();
    old_f = m_frame_cnt;
    pulse(1'b1, 1'b1, n, y);
    push_line(n, NO_CUT, 1'b1, 2'd2, y);
    guard = 0;
    while (exp_q.size() != 0 && guard < 200) begin
      tick();
      guard++;
      if (exp_q[0].cyc == cyc) begin
        e = exp_q.pop_front();
        checks++; if (dvp_d !== e.val) begin errors++; $display("FAIL simul_pix cyc %0d got %0h exp %0h", cyc - n, dvp_d, e.val); end
      end
    end
    if (exp_q.size() != 0) begin checks++; errors++; $display("FAIL simul_timeout left %0d exp 0", exp_q.size()); exp_q.delete(); end
    checks++; if (line_cnt !== 12'd1) begin errors++; $display("FAIL simul_line_cnt got %0d exp 1", line_cnt); end
    checks++; if (frame_cnt !== old_f + 16'd1) begin errors++; $display("FAIL simul_frame_cnt got %0d exp %0d", frame_cnt, old_f + 16'd1); end
  endtask

  task automatic test_lfsr();
    int unsigned   n, guard, first;
    logic [CW-1:0] y;
    exp_t          e;
    mode = 2'd3;
    for (int rep = 0; rep < 2; rep++) begin
      pulse(1'b0, 1'b1, n, y);
      repeat (2) tick();
      pulse(1'b1, 1'b0, n, y);
      first = n + 1 + OB_PIX + DATA_LAT;
      push_line(n, NO_CUT, 1'b1, 2'd3, y);
      guard = 0;
      while (exp_q.size() != 0 && guard < 200) begin
        tick();
        guard++;
        if (cyc == first) begin
          checks++; if (dvp_d !== 14'h2CE1) begin errors++; $display("FAIL lfsr_seed rep %0d got %0h exp 2ce1", rep, dvp_d); end
        end
        if (exp_q[0].cyc == cyc) begin
          e = exp_q.pop_front();
          checks++; if (dvp_d !== e.val) begin errors++; $display("FAIL lfsr_pix rep %0d cyc %0d got %0h exp %0h", rep, cyc - n, dvp_d, e.val); end
        end
      end
      if (exp_q.size() != 0) begin checks++; errors++; $display("FAIL lfsr_timeout left %0d exp 0", exp_q.size()); exp_q.delete(); end
    end
  endtask

  task automatic test_saturate();
    int unsigned   n;
    logic [CW-1:0] y;
    mode = 2'd0;
    for (int i = 0; i < 4100; i++) begin
      pulse(1'b1, 1'b0, n, y);
      tick();
    end
    checks++; if (line_cnt !== m_line_cnt) begin errors++; $display("FAIL sat_line_cnt_model got %0d exp %0d", line_cnt, m_line_cnt); end
    checks++; if (line_cnt !== CNT_MAX) begin errors++; $display("FAIL sat_line_cnt got %0d exp %0d", line_cnt, CNT_MAX); end
    pulse(1'b1, 1'b0, n, y);
    tick();
    checks++; if (line_cnt !== CNT_MAX) begin errors++; $display("FAIL sat_hold got %0d exp %0d", line_cnt, CNT_MAX); end
    repeat (40) tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    checks++; if (line_abort !== 1'b0) begin errors++; $display("FAIL sat_clr got %0b exp 0", line_abort); end
  endtask

  initial begin
    test_reset();
    test_hramp();
    test_vramp();
    test_abort();
    test_simultaneous();
    test_lfsr();
    test_saturate();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/afe_dvp_emulator.md
# afe_dvp_emulator

Synthesizable stand-in for the CCD analog front end on the DVP link. The system drives HSYNC/VSYNC toward the AFE and receives 14-bit pixel data back. This block is the opposite end: it samples those syncs and returns an AFE-like pixel stream with configurable optical-black lead-in, test patterns and pipeline latency. It sits in place of the AFE pins (DVP_D, DVP_HSYNC, DVP_VSYNC) for sensor-less bring-up and closed-loop simulation of the capture path.

## Interface
- DW, 14, pixel data width
- H_ACT, 1600, active pixels per line
- OB_PIX, 24, optical-black samples before active pixels
- OB_LEVEL, 14'd64, value driven during optical black
- DATA_LAT, 3, output pipeline depth in cycles (≥1)
- CW, 12, width of x/y counters

- clk  in  1  pixel clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- dvp_hsync  in  1  line sync from system, active-high
- dvp_vsync  in  1  frame sync from system, active-high
- mode  in  2  pattern: 0 fixed OB_LEVEL, 1 horizontal ramp, 2 vertical ramp, 3 LFSR noise
- clr  in  1  clears line_abort
- dvp_d  out  DW  pixel data toward system
- line_cnt  out  CW  lines started in current frame
- frame_cnt  out  16  vsync edges seen, wraps
- line_abort  out  1  sticky: hsync edge arrived while in OB or ACTIVE

## Operation
- Rising-edge detect on both syncs: registered previous sample; edge = in & ~prev.
- FSM states: IDLE, OB, ACTIVE, DONE. IDLE is the post-reset state; DONE is entered at end of line.
  - IDLE/DONE, hsync edge -> OB, with pixel counter x=0.
  - OB: emit OB_LEVEL; after OB_PIX cycles -> ACTIVE, x=0.
  - ACTIVE: emit pattern; x increments per cycle; after H_ACT pixels -> DONE.
  - DONE/IDLE: emit 0.
- Hsync edge in OB or ACTIVE: abort line, restart at OB with x=0, set line_abort. line_abort clears on clr; a set from an edge in the same cycle as clr wins.
- Vsync edge: y=0, line_cnt=0, frame_cnt+1, LFSR reseeded to 16'hACE1. FSM state is not changed.
- Vsync and hsync edges in the same cycle: vsync is applied first. The line starts as y=0, and line_cnt becomes 1.
- Hsync edge without vsync: line_cnt increments and saturates at 2^CW−1. y = line_cnt before increment, so the first line after vsync is y=0.
- mode is sampled at the hsync edge and held for the whole line.
- Pattern arithmetic, all truncated to DW bits:
  - mode 1: value = x.
  - mode 2: value = y.
  - mode 3: value = LFSR[13:0]. The LFSR is 16-bit Fibonacci, taps 16,14,13,11. It advances once per ACTIVE pixel after its value is used.
- Reset mid-line: on the next edge, the FSM is IDLE, all counters are 0, the pipeline is flushed to 0 and line_abort is 0.

## Timing
- Every output resets to 0. LFSR resets to 16'hACE1.
- Let N be the first cycle in which hsync is sampled high (edge). State is OB from edge N+1.
- The stage-0 sample is combinational from state/x/y. It passes through DATA_LAT registers.
- First OB sample appears on dvp_d in cycle N+1+DATA_LAT.
- First active pixel appears in cycle N+1+OB_PIX+DATA_LAT.
- Last active pixel appears in cycle N+OB_PIX+H_ACT+DATA_LAT. dvp_d is 0 from the following cycle.
- line_cnt and frame_cnt update at edge N+1. They are not delayed by DATA_LAT.
- No back-pressure. Exactly one sample per cycle, always.

## Structure
- Package afe_emu_pkg holds:
  - mode enum (MODE_FIXED, MODE_HRAMP, MODE_VRAMP, MODE_LFSR)
  - state enum
  - LFSR_SEED = 16'hACE1 and the tap mask
- Sub-module afe_emu_delay is a parameterized DATA_LAT-deep register pipeline with synchronous clear.
- FSM, counters and pattern mux are in the top of the block.

## Test plan
- Reset: hold rst 4 cycles mid-line -> dvp_d=0, line_cnt=0, frame_cnt=0, line_abort=0 on the first cycle after release.
- Bench params H_ACT=16, OB_PIX=4, DATA_LAT=3; mode 1; hsync edge at cycle 10 -> dvp_d=64 in cycles 14–17, 0..15 in cycles 18–33, 0 from cycle 34.
- Mode 2; vsync edge, then three hsync lines -> lines carry constant 0, 1, 2; frame_cnt=1; line_cnt=3.
- Second hsync edge 8 cycles into a line -> line_abort=1; the OB/active sequence restarts from x=0. clr pulse -> line_abort=0.
- Vsync and hsync edges in the same cycle -> line data y=0; line_cnt=1; frame_cnt increments by 1.
- Mode 3 after a vsync -> first active pixel is 14'h2CE1, and the following pixels match a Fibonacci x^16+x^14+x^13+x^11+1 model. A reseed on the next vsync repeats 14'h2CE1.
